// File: rtl/lcd_cmd_seq_if.sv
// Host and controller signals of the LCD command sequencer.
// master: the sequencer itself; slave: the host/controller side driving it.
interface lcd_cmd_seq_if #(
  parameter int unsigned AW = 4
);
  // host push side
  logic          push;
  logic [2:0]    push_cmd;
  logic          full;
  logic [AW:0]   fifo_cnt;
  // controller handshake
  logic          busy;
  logic          done;
  logic [2:0]    cmd;
  logic          cmd_valid;
  // status
  logic [7:0]    issued_cnt;
  logic          ovf;
  logic          ack_err;
  logic          finished;

  modport master (
    input  push, push_cmd, busy, done,
    output full, fifo_cnt, cmd, cmd_valid, issued_cnt, ovf, ack_err, finished
  );

  modport slave (
    output push, push_cmd, busy, done,
    input  full, fifo_cnt, cmd, cmd_valid, issued_cnt, ovf, ack_err, finished
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Command sequencer in front of the LCD image controller: queues 3-bit opcodes
// in a circular FIFO and issues them one at a time over cmd/cmd_valid/busy,
// after the controller's power-up load and until a Write is acknowledged.
module lcd_cmd_seq #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  lcd_cmd_seq_if.master  bus
);

  localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    ISSUE,
    ACK,
    WAITB,
    FIN
  } state_t;

  state_t        state;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_next;
  logic          full_q;
  logic          ovf_q;
  logic          empty;
  logic          wr_en;
  logic          pop;
  logic [2:0]    head;

  logic [2:0]    cmd_q;
  logic          cmd_valid_q;
  logic [7:0]    issued_q;
  logic          ack_err_q;
  logic          finished_q;
  logic [TW-1:0] tmo;

  // FIFO control: push gated by the registered full flag, pop only from IDLE
  always_comb begin
    empty = (cnt == '0);
    wr_en = bus.push && !full_q;
    pop   = (state == IDLE) && !bus.done && !bus.busy && !empty;
    head  = mem[rd_ptr];
    cnt_next = cnt;
    case ({wr_en, pop})
      2'b10:   cnt_next = cnt + (AW+1)'(1);
      2'b01:   cnt_next = cnt - (AW+1)'(1);
      default: cnt_next = cnt;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.push_cmd;
    end
  end

  // FIFO pointers, occupancy, full and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt    <= cnt_next;
      full_q <= (cnt_next == (AW+1)'(DEPTH));
      if (bus.push && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Issue FSM with registered strobe, command and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      issued_q    <= '0;
      ack_err_q   <= 1'b0;
      finished_q  <= 1'b0;
      tmo         <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (bus.done && (state != BOOT)) begin
        state      <= FIN;
        finished_q <= 1'b1;
      end else begin
        case (state)
          BOOT: begin
            if (!bus.busy) begin
              state <= IDLE;
            end
          end
          IDLE: begin
            if (pop) begin
              cmd_q       <= head;
              cmd_valid_q <= 1'b1;
              state       <= ISSUE;
            end
          end
          ISSUE: begin
            tmo   <= '0;
            state <= ACK;
          end
          ACK: begin
            if (bus.busy) begin
              issued_q <= issued_q + 8'd1;
              if (cmd_q == 3'b000) begin
                state      <= FIN;
                finished_q <= 1'b1;
              end else begin
                state <= WAITB;
              end
            end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
              // ACK_TIMEOUT cycles spent in ACK: command is dropped, not retried
              ack_err_q <= 1'b1;
              state     <= IDLE;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end
          WAITB: begin
            if (!bus.busy) begin
              state <= IDLE;
            end
          end
          FIN: begin
            finished_q <= 1'b1;
          end
          default: begin
            state <= BOOT;
          end
        endcase
      end
    end
  end

  assign bus.full       = full_q;
  assign bus.fifo_cnt   = cnt;
  assign bus.ovf        = ovf_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.issued_cnt = issued_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.finished   = finished_q;

endmodule

// File: doc/lcd_cmd_seq.md
# lcd_cmd_seq

Command sequencer directly upstream of the LCD image controller. Buffers 3-bit commands pushed by a host/testbench into a FIFO and issues them to the controller one at a time over the `cmd`/`cmd_valid`/`busy` handshake. Waits for the controller's power-up image load to finish before issuing anything. Stops issuing after a Write command (opcode 3'b000) has been accepted. Reports issue count, overflow, and acknowledge-timeout status.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of 2.
- `AW`, 4: FIFO pointer width, log2(DEPTH).
- `ACK_TIMEOUT`, 15: cycles to wait for `busy` high after an issue before declaring a lost command.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs return to reset values immediately.
- `push` in 1: host writes `push_cmd` into the FIFO this cycle.
- `push_cmd` in 3: command opcode (000 Write, 001 Up, 010 Down, 011 Left, 100 Right, 101 Average, 110 MirrorX, 111 MirrorY).
- `full` out 1: FIFO holds DEPTH entries (registered).
- `fifo_cnt` out AW+1: current FIFO occupancy.
- `busy` in 1: controller busy.
- `done` in 1: controller finished writing the image buffer.
- `cmd` out 3: opcode presented to the controller.
- `cmd_valid` out 1: command strobe, exactly one cycle per issue.
- `issued_cnt` out 8: commands acknowledged by the controller; wraps 255→0.
- `ovf` out 1: sticky; a push was dropped.
- `ack_err` out 1: sticky; an acknowledge timeout occurred.
- `finished` out 1: sticky; a Write was acknowledged or `done` was seen.

## Operation
- FIFO: circular buffer with rd/wr pointers of AW bits. Push is accepted iff `full`=0 at the clock edge. A push while `full`=1 is dropped and sets `ovf`, even if a pop happens in the same cycle. Simultaneous accepted push and pop leave `fifo_cnt` unchanged. Order is strict FIFO.
- FSM states: BOOT, IDLE, ISSUE, ACK, WAITB, FIN.
  - BOOT (reset state): wait for `busy`=0, then go to IDLE. The controller holds `busy`=1 during its ROM load.
  - IDLE: if `busy`=0 and FIFO non-empty: pop the head into `cmd`, set `cmd_valid`=1, go to ISSUE. Otherwise stay.
  - ISSUE: lasts 1 cycle with `cmd_valid`=1. Next edge: `cmd_valid`=0, clear the timeout counter, go to ACK.
  - ACK: on `busy`=1, increment `issued_cnt`. If `cmd`=000, go to FIN; otherwise go to WAITB. If the counter reaches ACK_TIMEOUT with `busy` still 0: set `ack_err`, do not count the command, return to IDLE. The command is dropped, not retried.
  - WAITB: on `busy`=0, go to IDLE.
  - FIN: terminal until reset; `finished`=1. The FIFO still accepts pushes but nothing is issued.
- `done`=1 in any state except BOOT forces FIN on the next edge and sets `finished`.
- `cmd` holds its last issued value after `cmd_valid` drops.

## Timing
- Reset values: `cmd`=000, `cmd_valid`=0, `full`=0, `fifo_cnt`=0, `issued_cnt`=0, `ovf`=0, `ack_err`=0, `finished`=0; FSM in BOOT; pointers at 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Issue latency: if the FIFO is non-empty and `busy`=0 in IDLE, `cmd_valid` rises on the next edge.
- Minimum spacing between consecutive `cmd_valid` pulses is 4 cycles (ISSUE, ACK, WAITB, IDLE) when the controller returns `busy` high for one cycle.
- `fifo_cnt` and `full` update on the edge that accepts a push or performs a pop. A pop happens on the IDLE→ISSUE edge.
- Reset asserted mid-operation: `cmd_valid` drops asynchronously and the FIFO contents are discarded. After release the FSM starts in BOOT and waits for `busy` low again.

## Test plan
- Reset, `busy`=1 for 70 cycles, then 0, with 3 pushed commands → no `cmd_valid` before `busy` falls; first `cmd_valid` appears 2 edges after `busy` falls.
- Push 001,100,101; the model raises `busy` for 1 cycle after each strobe → three single-cycle strobes in order 001,100,101; `issued_cnt`=3; `fifo_cnt`=0.
- With `busy` held 1, push 17 commands → `full`=1 after the 16th push; 17th push dropped; `ovf`=1; `fifo_cnt`=16; after release, 16 commands issue in order.
- Issue 011 with a model that never raises `busy` → after ACK_TIMEOUT (15) cycles in ACK, `ack_err`=1, `issued_cnt` unchanged, next queued command is issued.
- Push 010,000,001 → 000 is acknowledged, `finished`=1, `issued_cnt`=2; 001 remains queued (`fifo_cnt`=1) and `cmd_valid` never rises again.
- Assert `reset` during ACK of a command → all outputs at reset values immediately; after release, FSM waits in BOOT and a fresh push sequence issues correctly.
